cnt_down_ld: RTL

Loadable down-counter timer with a run/pause state machine, optional auto-reload and a terminal-count event. It is the decrementing counterpart of the team's up-counter with enable/clear/overflow. It sits in the timer/prescaler path: software or a controller loads a period, starts it, and consumes `done_o` or `tc_flag_o` as the expiry event. All outputs are registered.

---
 rtl/cnt_down_ld.sv | 116 +++++++++++
 1 files changed

// File: rtl/cnt_down_ld.sv
// Loadable down-counter timer with IDLE/RUN/PAUSE control, optional auto-reload
// and a terminal-count pulse plus sticky flag. All outputs are registered.
module cnt_down_ld #(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 cnt_en_i,
  input  logic                 auto_reload_i,
  input  logic                 flag_clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 busy_o,
  output logic                 paused_o,
  output logic                 done_o,
  output logic                 tc_flag_o
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e                 r_state_q, r_state_d;
  logic [CNT_WIDTH-1:0]   r_cnt_q, r_cnt_d;
  logic [CNT_WIDTH-1:0]   r_reload_q, r_reload_d;
  logic                   r_busy_q, r_busy_d;
  logic                   r_paused_q, r_paused_d;
  logic                   r_done_q, r_done_d;
  logic                   r_flag_q, r_flag_d;

  logic                   w_tick;
  logic                   w_term;
  logic                   w_reload;
  logic                   w_cnt_nz;

  // A tick only counts if the state was already RUN before this edge.
  assign w_tick   = cnt_en_i && (r_state_q == StRun) && !load_i && !stop_i;
  assign w_term   = w_tick && (r_cnt_q == CNT_WIDTH'(1));
  assign w_reload = auto_reload_i && (r_reload_q != '0);
  assign w_cnt_nz = (r_cnt_q != '0);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state_q  <= StIdle;
      r_cnt_q    <= '0;
      r_reload_q <= '0;
      r_busy_q   <= 1'b0;
      r_paused_q <= 1'b0;
      r_done_q   <= 1'b0;
      r_flag_q   <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      r_cnt_q    <= r_cnt_d;
      r_reload_q <= r_reload_d;
      r_busy_q   <= r_busy_d;
      r_paused_q <= r_paused_d;
      r_done_q   <= r_done_d;
      r_flag_q   <= r_flag_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    if (load_i) begin
      r_state_d = StIdle;
    end else begin
      unique case (r_state_q)
        StRun: begin
          if (stop_i) begin
            r_state_d = StPause;
          end else if (w_term && !w_reload) begin
            r_state_d = StIdle;
          end
        end
        StIdle, StPause: begin
          if (start_i && w_cnt_nz) begin
            r_state_d = StRun;
          end
        end
        default: r_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    r_cnt_d    = r_cnt_q;
    r_reload_d = r_reload_q;
    r_flag_d   = r_flag_q;
    if (load_i) begin
      r_cnt_d    = load_val_i;
      r_reload_d = load_val_i;
      r_flag_d   = 1'b0;
    end else if (w_term) begin
      r_cnt_d  = w_reload ? r_reload_q : '0;
      r_flag_d = 1'b1;
    end else begin
      if (w_tick && w_cnt_nz) begin
        r_cnt_d = r_cnt_q - CNT_WIDTH'(1);
      end
      if (flag_clr_i) begin
        r_flag_d = 1'b0;
      end
    end
    r_done_d   = w_term;
    r_busy_d   = (r_state_d == StRun);
    r_paused_d = (r_state_d == StPause);
  end

  assign cnt_o     = r_cnt_q;
  assign busy_o    = r_busy_q;
  assign paused_o  = r_paused_q;
  assign done_o    = r_done_q;
  assign tc_flag_o = r_flag_q;

endmodule
